// File: rtl/ram_arb_pkg.sv
// Shared definitions for the SRAM port-A arbiter.
// Host index constants and the round-robin search helper.
package ram_arb_pkg;

    localparam int unsigned HostCoreD    = 0;
    localparam int unsigned HostDMAWrite = 1;

    // Upper bound on hosts the search helper can scan.
    localparam int unsigned MaxHosts  = 8;
    localparam int unsigned MaxHostsW = 3;

    // First requesting host strictly after 'last', wrapping modulo n.
    // Returns 'last' when nobody requests.
    function automatic int unsigned rr_next(
        input logic [MaxHosts-1:0] req,
        input int unsigned         last,
        input int unsigned         n
    );
        int unsigned sel;
        int unsigned idx;
        logic        found;
        sel   = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MaxHosts; k++) begin
            if (k <= n) begin
                idx = (last + k) % n;
                if (!found && req[idx[MaxHostsW-1:0]]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Host-side (vectored) and device-side req/gnt bundles
// for the SRAM port-A arbiter.
interface ram_host_if #(
    parameter int unsigned NrHosts = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
);
    logic [NrHosts-1:0]        req;
    logic [NrHosts-1:0]        we;
    logic [NrHosts*DW/8-1:0]   be;
    logic [NrHosts*AW-1:0]     addr;
    logic [NrHosts*DW-1:0]     wdata;
    logic [NrHosts-1:0]        gnt;
    logic [NrHosts-1:0]        rvalid;
    logic [DW-1:0]             rdata;
    logic [NrHosts-1:0]        err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

interface ram_dev_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req;
    logic          we;
    logic [DW/8-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ram_arb_id_fifo.sv
// In-order FIFO of issuing-host ids for outstanding SRAM transactions.
// Push on grant, pop on response; Depth must be a power of 2.
module ram_arb_id_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned IdW   = 1
) (
    input  logic                     clk_sys,
    input  logic                     rst_sys_n,
    input  logic                     push,
    input  logic [IdW-1:0]           push_id,
    input  logic                     pop,
    output logic [IdW-1:0]           pop_id,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [IdW-1:0]  mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_id  = mem_q[rd_ptr_q];

    // Storage for queued ids, cleared so a reset never exposes stale entries
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_id;
        end
    end

    // Pointers wrap naturally because Depth is a power of 2
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            count <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with burst lock sharing SRAM port A between hosts.
// In-order responses are routed back via an id FIFO.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned NrHosts  = 2,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MaxBurst = 4,
    parameter int unsigned RspDepth = 4
) (
    input  logic      clk_sys,
    input  logic      rst_sys_n,
    ram_host_if.slave host,
    ram_dev_if.master dev,
    output logic      busy,
    output logic      rsp_underflow
);
    localparam int unsigned BW     = DW / 8;
    localparam int unsigned IdW    = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned CntW   = $clog2(RspDepth) + 1;
    localparam int unsigned BurstW = $clog2(MaxBurst + 1);

    logic [IdW-1:0]      last_q;
    logic [IdW-1:0]      winner;
    logic [IdW-1:0]      head_id;
    logic [BurstW-1:0]   burst_q;
    logic [CntW-1:0]     count;
    logic [MaxHosts-1:0] req_ext;
    logic                full;
    logic                empty;
    logic                any_req;
    logic                req_raw;
    logic                lock;
    logic                grant;
    logic                pop;
    logic                stray;

    assign any_req = |host.req;
    assign req_raw = any_req & ~full;
    assign grant   = req_raw & dev.gnt;
    assign pop     = dev.rvalid & ~empty;
    assign stray   = dev.rvalid & empty;
    assign busy    = (count != '0);
    assign dev.req = req_raw & rst_sys_n;

    // Widen the request vector to the search helper's fixed width
    always_comb begin
        req_ext = '0;
        req_ext[NrHosts-1:0] = host.req;
    end

    // Burst owner keeps the port while it has budget, else round-robin
    always_comb begin
        lock = host.req[last_q]
            && (burst_q != '0)
            && (burst_q < BurstW'(MaxBurst))
            && !full;
        if (lock) begin
            winner = last_q;
        end else begin
            winner = IdW'(rr_next(req_ext, 32'(last_q), NrHosts));
        end
    end

    // Forward the winner's request fields to the RAM
    always_comb begin
        dev.we    = 1'b0;
        dev.be    = '0;
        dev.addr  = '0;
        dev.wdata = '0;
        if (dev.req) begin
            dev.we    = host.we[winner];
            dev.be    = host.be[32'(winner)*BW +: BW];
            dev.addr  = host.addr[32'(winner)*AW +: AW];
            dev.wdata = host.wdata[32'(winner)*DW +: DW];
        end
    end

    // One-hot grant back to the winner
    always_comb begin
        host.gnt = '0;
        if (grant && rst_sys_n) begin
            host.gnt[winner] = 1'b1;
        end
    end

    // Route the in-order response to the host at the FIFO head
    always_comb begin
        host.rvalid = '0;
        host.err    = '0;
        host.rdata  = rst_sys_n ? dev.rdata : '0;
        if (pop && rst_sys_n) begin
            host.rvalid[head_id] = 1'b1;
            host.err[head_id]    = dev.err;
        end
    end

    // Track burst owner; an exhausted lone owner restarts its burst at 1
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            last_q  <= IdW'(NrHosts - 1);
            burst_q <= '0;
        end else if (grant) begin
            if (winner != last_q) begin
                last_q  <= winner;
                burst_q <= BurstW'(1);
            end else if (burst_q < BurstW'(MaxBurst)) begin
                burst_q <= burst_q + 1'b1;
            end else begin
                burst_q <= BurstW'(1);
            end
        end
    end

    // Sticky flag for a response with nothing outstanding
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            rsp_underflow <= 1'b0;
        end else if (stray) begin
            rsp_underflow <= 1'b1;
        end
    end

    ram_arb_id_fifo #(
        .Depth (RspDepth),
        .IdW   (IdW)
    ) u_id_fifo (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .push      (grant),
        .push_id   (winner),
        .pop       (pop),
        .pop_id    (head_id),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a small SRAM model.
// Expected grants/responses are queued at stimulus time, checked by a monitor.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    logic clk_sys   = 1'b0;
    logic rst_sys_n = 1'b0;
    logic busy;
    logic rsp_underflow;

    always #5 clk_sys = ~clk_sys;

    ram_host_if #(.NrHosts(2), .AW(32), .DW(32)) host_bus ();
    ram_dev_if  #(.AW(32), .DW(32))              dev_bus ();

    ram_port_arbiter #(
        .NrHosts(2), .AW(32), .DW(32), .MaxBurst(4), .RspDepth(4)
    ) dut (
        .clk_sys       (clk_sys),
        .rst_sys_n     (rst_sys_n),
        .host          (host_bus),
        .dev           (dev_bus),
        .busy          (busy),
        .rsp_underflow (rsp_underflow)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        int          host;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } ram_rsp_t;

    txn_t     hq0[$];
    txn_t     hq1[$];
    int       exp_gnt[$];
    rsp_t     exp_rsp[$];
    ram_rsp_t pend[$];
    logic [31:0] mem [256];

    int checks     = 0;
    int errors     = 0;
    int gnt_seen   = 0;
    int rsp_credit = -1;
    bit force_req  = 1'b0;
    bit ur_pulse   = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] rd_val(input logic [31:0] addr);
        return 32'hA500_0000 | {24'h0, addr[9:2]};
    endfunction

    function automatic logic [31:0] wd(input int k);
        return 32'h1111_0000 + 32'(k);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        rst_sys_n = 1'b0;
        cycles(2);
        rst_sys_n = 1'b1;
    endtask

    task automatic issue(input int h, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        if (h == 0) hq0.push_back(t);
        else        hq1.push_back(t);
    endtask

    task automatic expect_txn(input int h, input logic [31:0] data, input logic err);
        rsp_t r;
        r.host = h; r.data = data; r.err = err;
        exp_gnt.push_back(h);
        exp_rsp.push_back(r);
    endtask

    task automatic wait_drain(input string name, input int budget, input bit need_rsp);
        int n = 0;
        while ((exp_gnt.size() != 0 || (need_rsp && exp_rsp.size() != 0))
               && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        if (exp_gnt.size() != 0 || (need_rsp && exp_rsp.size() != 0)) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: gnt left %0d rsp left %0d, required 0",
                     name, exp_gnt.size(), exp_rsp.size());
            exp_gnt.delete(); exp_rsp.delete(); hq0.delete(); hq1.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    end

    // Host and SRAM driver: updates inputs just after each rising edge
    always @(posedge clk_sys) begin
        ram_rsp_t r;
        #1;
        host_bus.req = '0; host_bus.we = '0; host_bus.be = '0;
        host_bus.addr = '0; host_bus.wdata = '0;
        if (hq0.size() != 0) begin
            host_bus.req[0] = 1'b1; host_bus.we[0] = hq0[0].we;
            host_bus.be[3:0] = 4'hF; host_bus.addr[31:0] = hq0[0].addr;
            host_bus.wdata[31:0] = hq0[0].wdata;
        end
        if (hq1.size() != 0) begin
            host_bus.req[1] = 1'b1; host_bus.we[1] = hq1[0].we;
            host_bus.be[7:4] = 4'hF; host_bus.addr[63:32] = hq1[0].addr;
            host_bus.wdata[63:32] = hq1[0].wdata;
        end
        if (force_req) host_bus.req = 2'b11;
        dev_bus.rvalid = 1'b0; dev_bus.rdata = '0; dev_bus.err = 1'b0;
        if (ur_pulse) begin
            dev_bus.rvalid = 1'b1; dev_bus.rdata = 32'hDEAD_BEEF;
            ur_pulse = 1'b0;
        end else if (pend.size() != 0 && rsp_credit != 0) begin
            r = pend.pop_front();
            dev_bus.rvalid = 1'b1; dev_bus.rdata = r.data; dev_bus.err = r.err;
            if (rsp_credit > 0) rsp_credit--;
        end
    end

    // Accept side: retire granted host requests and queue SRAM responses
    always @(negedge clk_sys) begin
        txn_t     t;
        ram_rsp_t r;
        logic [7:0] idx;
        if (host_bus.gnt[0] && hq0.size() != 0) t = hq0.pop_front();
        if (host_bus.gnt[1] && hq1.size() != 0) t = hq1.pop_front();
        if (dev_bus.req && dev_bus.gnt) begin
            idx   = dev_bus.addr[9:2];
            r.err = (dev_bus.addr[15:12] == 4'hE);
            if (dev_bus.we) begin
                r.data   = '0;
                mem[idx] = dev_bus.wdata;
            end else begin
                r.data = mem[idx];
            end
            pend.push_back(r);
        end
    end

    // Monitor: compare every grant and response against the scoreboard
    always @(negedge clk_sys) begin
        rsp_t r;
        int   g;
        if (host_bus.gnt != '0) begin
            gnt_seen++;
            if (exp_gnt.size() == 0) begin
                checks++; errors++;
                $display("FAIL gnt_unexpected: got %b required none", host_bus.gnt);
            end else begin
                g = exp_gnt.pop_front();
                chk("gnt", 64'(host_bus.gnt), 64'(1) << g);
            end
        end
        if (host_bus.rvalid != '0) begin
            if (exp_rsp.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected: got %b required none", host_bus.rvalid);
            end else begin
                r = exp_rsp.pop_front();
                chk("rsp_valid", 64'(host_bus.rvalid), 64'(1) << r.host);
                chk("rsp_data", 64'(host_bus.rdata), 64'(r.data));
                chk("rsp_err", 64'(host_bus.err), {63'h0, r.err} << r.host);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dev_bus.gnt = 1'b1; dev_bus.rvalid = 1'b0;
        dev_bus.rdata = '0; dev_bus.err = 1'b0;
        host_bus.req = '0; host_bus.we = '0; host_bus.be = '0;
        host_bus.addr = '0; host_bus.wdata = '0;

        // Reset holds every output low even with requests present
        force_req = 1'b1;
        cycles(3);
        chk("rst_dev_req", 64'(dev_bus.req), 64'h0);
        chk("rst_gnt", 64'(host_bus.gnt), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_underflow", 64'(rsp_underflow), 64'h0);
        force_req = 1'b0;
        cycles(2);
        rst_sys_n = 1'b1;

        // Lone core host: six back-to-back reads
        for (int k = 0; k < 6; k++) begin
            issue(HostCoreD, 1'b0, 32'(4 * k), 32'h0);
            expect_txn(HostCoreD, rd_val(32'(4 * k)), 1'b0);
        end
        wait_drain("single_host", 60, 1'b1);

        // Both hosts continuously: bursts of four alternate, host0 first
        do_reset();
        for (int k = 0; k < 8; k++) begin
            issue(HostCoreD, 1'b0, 32'h40 + 32'(4 * k), 32'h0);
            issue(HostDMAWrite, 1'b1, 32'h200 + 32'(4 * k), wd(k));
        end
        for (int k = 0; k < 4; k++) expect_txn(0, rd_val(32'h40 + 32'(4 * k)), 1'b0);
        for (int k = 0; k < 4; k++) expect_txn(1, 32'h0, 1'b0);
        for (int k = 4; k < 8; k++) expect_txn(0, rd_val(32'h40 + 32'(4 * k)), 1'b0);
        for (int k = 4; k < 8; k++) expect_txn(1, 32'h0, 1'b0);
        wait_drain("burst_rr", 80, 1'b1);

        // Responses held: FIFO fills at four, one response frees one slot
        do_reset();
        rsp_credit = 0;
        gnt_seen   = 0;
        for (int k = 0; k < 4; k++) begin
            issue(0, 1'b0, 32'h80 + 32'(4 * k), 32'h0);
            issue(1, 1'b0, 32'h200 + 32'(4 * k), 32'h0);
        end
        for (int k = 0; k < 4; k++) expect_txn(0, rd_val(32'h80 + 32'(4 * k)), 1'b0);
        for (int k = 0; k < 4; k++) expect_txn(1, wd(k), 1'b0);
        cycles(10);
        chk("full_gnt_count", 64'(gnt_seen), 64'd4);
        chk("full_dev_req", 64'(dev_bus.req), 64'h0);
        chk("full_busy", 64'(busy), 64'h1);
        rsp_credit = 1;
        cycles(6);
        chk("one_slot_gnt_count", 64'(gnt_seen), 64'd5);
        chk("one_slot_dev_req", 64'(dev_bus.req), 64'h0);
        rsp_credit = -1;
        wait_drain("fifo_full", 60, 1'b1);

        // Interleaved h0,h1,h0 with an error on the middle response
        do_reset();
        rsp_credit = 0;
        issue(0, 1'b0, 32'h10, 32'h0);
        expect_txn(0, rd_val(32'h10), 1'b0);
        wait_drain("il_g0", 20, 1'b0);
        issue(1, 1'b0, 32'hE004, 32'h0);
        expect_txn(1, rd_val(32'hE004), 1'b1);
        wait_drain("il_g1", 20, 1'b0);
        issue(0, 1'b0, 32'h14, 32'h0);
        expect_txn(0, rd_val(32'h14), 1'b0);
        wait_drain("il_g2", 20, 1'b0);
        rsp_credit = -1;
        wait_drain("interleave", 30, 1'b1);

        // Stray response with nothing outstanding
        do_reset();
        ur_pulse = 1'b1;
        cycles(3);
        chk("underflow_set", 64'(rsp_underflow), 64'h1);
        cycles(5);
        chk("underflow_sticky", 64'(rsp_underflow), 64'h1);
        chk("underflow_busy", 64'(busy), 64'h0);

        // Reset with three in flight, then a stale response arrives
        do_reset();
        chk("underflow_clear", 64'(rsp_underflow), 64'h0);
        rsp_credit = 0;
        for (int k = 0; k < 3; k++) begin
            issue(0, 1'b0, 32'h20 + 32'(4 * k), 32'h0);
            exp_gnt.push_back(0);
        end
        wait_drain("inflight_gnt", 20, 1'b0);
        chk("inflight_busy", 64'(busy), 64'h1);
        @(negedge clk_sys);
        rst_sys_n = 1'b0;
        #1;
        chk("rst_busy_now", 64'(busy), 64'h0);
        chk("rst_req_now", 64'(dev_bus.req), 64'h0);
        cycles(2);
        rst_sys_n = 1'b1;
        cycles(1);
        chk("post_rst_underflow", 64'(rsp_underflow), 64'h0);
        rsp_credit = 1;
        cycles(4);
        chk("stale_underflow", 64'(rsp_underflow), 64'h1);
        chk("stale_busy", 64'(busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
